mmio_io_bridge: RTL and testbench



---
 rtl/mmio_io_bridge.sv | 173 +++++++++++++++++
 tb/tb_mmio_io_bridge.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O responder for the Riscv151 core: UART TX/RX byte ports plus cycle/instret counters.
// Build option: define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO instead of a single-byte RX register.
module mmio_io_bridge #(
    parameter int CPU_CLOCK_FREQ = 50_000_000,
    parameter int RX_FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retired,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    // Handshakes on both UART sides: a byte moves on a rising edge where valid && ready.
    // tx_valid holds tx_data stable until accepted; rx_ready never depends on rx_valid.

    logic       hit;
    logic [7:0] off;
    logic       rd_status, rd_rx, wr_tx, wr_clr;

    assign hit       = (addr[31:28] == 4'h8);
    assign off       = addr[7:0];
    assign rd_status = re && hit && (off == 8'h00);
    assign rd_rx     = re && hit && (off == 8'h04);
    assign wr_tx     = we && hit && (off == 8'h08);
    assign wr_clr    = we && hit && (off == 8'h18);

    logic unused_ok;
    assign unused_ok = ^{addr[27:8], wdata[31:8], rd_status,
                         (CPU_CLOCK_FREQ > 0), (RX_FIFO_DEPTH > 0)};

    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ins_cnt_q, ins_cnt_d;

    logic       rx_avail, rx_full, rx_push, rx_pop;
    logic [7:0] rx_head;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = rd_rx && rx_avail;

`ifdef UART_RX_FIFO_EN
    localparam int PW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(RX_FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [7:0]    mem_q [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;

    assign rx_avail = (cnt_q != '0);
    assign rx_full  = (cnt_q == DEPTH_C);
    assign rx_head  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (rx_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (rx_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rx_push) mem_q[wr_ptr_q] <= rx_data;
    end
`else
    logic [7:0] rx_byte_q;
    logic       rx_vld_q;

    assign rx_avail = rx_vld_q;
    assign rx_full  = rx_vld_q;
    assign rx_head  = rx_byte_q;

    // Push only happens when empty and pop only when full, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte_q <= 8'h00;
            rx_vld_q  <= 1'b0;
        end else if (rx_push) begin
            rx_byte_q <= rx_data;
            rx_vld_q  <= 1'b1;
        end else if (rx_pop) begin
            rx_vld_q  <= 1'b0;
        end
    end
`endif

    // Load data reflects state before the edge, like a block RAM read.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = 32'h0;
            if (hit) begin
                case (off)
                    8'h00:   rdata_d = {30'b0, rx_avail, !tx_valid_q};
                    8'h04:   rdata_d = rx_avail ? {24'b0, rx_head} : 32'h0;
                    8'h10:   rdata_d = cyc_cnt_q;
                    8'h14:   rdata_d = ins_cnt_q;
                    default: rdata_d = 32'h0;
                endcase
            end
        end
    end

    // A store landing while a byte is still pending is dropped; software polls tx_free.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end else if (wr_tx && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wdata[7:0];
        end
    end

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ins_cnt_d = inst_retired ? (ins_cnt_q + 32'd1) : ins_cnt_q;
        if (wr_clr) begin
            cyc_cnt_d = 32'h0;
            ins_cnt_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= 32'h0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cyc_cnt_q  <= 32'h0;
            ins_cnt_q  <= 32'h0;
        end else begin
            rdata_q    <= rdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cyc_cnt_q  <= cyc_cnt_d;
            ins_cnt_q  <= ins_cnt_d;
        end
    end

    assign rdata    = rdata_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Self-checking bench for mmio_io_bridge; load results go through an expected-value queue.
// Follows the UART_RX_FIFO_EN build option of the design.
module tb_mmio_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        we, re, inst_retired;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        rd_pend = 1'b0;

    mmio_io_bridge #(.CPU_CLOCK_FREQ(50_000_000), .RX_FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retired(inst_retired), .rdata(rdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a load issued before an edge is compared on the following falling edge.
    always @(posedge clk) rd_pend <= re && !rst;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq(tag_q.pop_front(), rdata, exp_q.pop_front());
            end
        end
    end

    // Driver tasks: called at a falling edge, return at the next falling edge.
    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic drive_rx(input logic [7:0] b);
        check_eq("rx_ready_before_push", {31'b0, rx_ready}, 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    localparam logic [31:0] A_STAT = 32'h8000_0000;
    localparam logic [31:0] A_RX   = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INS  = 32'h8000_0014;
    localparam logic [31:0] A_CLR  = 32'h8000_0018;

    initial begin
        int m;
        logic [7:0] b;
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        inst_retired = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_eq("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        do_read(A_STAT, 32'h1, "stat_after_reset");

        // TX holding register under back-pressure
        do_write(32'h0000_0008, 32'h77);
        check_eq("tx_miss_ignored", {31'b0, tx_valid}, 32'h0);
        do_write(A_TX, 32'hFFFF_FF41);
        for (int i = 0; i < 5; i++) begin
            check_eq("tx_hold_valid", {31'b0, tx_valid}, 32'h1);
            check_eq("tx_hold_data", {24'b0, tx_data}, 32'h41);
            @(negedge clk);
        end
        do_write(A_TX, 32'h42);
        check_eq("tx_drop_data", {24'b0, tx_data}, 32'h41);
        do_read(A_STAT, 32'h0, "stat_tx_busy");
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check_eq("tx_handshake_clear", {31'b0, tx_valid}, 32'h0);
        do_read(A_STAT, 32'h1, "stat_tx_free");

        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            do_write(A_TX, {24'b0, b});
            check_eq("tx_rand_data", {24'b0, tx_data}, {24'b0, b});
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            check_eq("tx_rand_clear", {31'b0, tx_valid}, 32'h0);
        end

        // RX ordering and empty reads
`ifdef UART_RX_FIFO_EN
        drive_rx(8'h10); drive_rx(8'h20); drive_rx(8'h30);
        do_read(A_RX, 32'h10, "rx_pop0");
        do_read(A_RX, 32'h20, "rx_pop1");
        do_read(A_RX, 32'h30, "rx_pop2");
`else
        drive_rx(8'h10); do_read(A_RX, 32'h10, "rx_pop0");
        drive_rx(8'h20); do_read(A_RX, 32'h20, "rx_pop1");
        drive_rx(8'h30); do_read(A_RX, 32'h30, "rx_pop2");
`endif
        do_read(A_RX, 32'h0, "rx_empty_read");
        do_read(A_STAT, 32'h1, "stat_rx_empty");

        // Status read during a push shows the pre-push state
        rx_data = 8'h5C; rx_valid = 1'b1;
        do_read(A_STAT, 32'h1, "stat_same_cycle_push");
        rx_valid = 1'b0;
        do_read(A_STAT, 32'h3, "stat_rx_avail");
        do_read(A_RX, 32'h5C, "rx_pop_5c");

        // Full buffer: pop while a byte waits, it enters the cycle after
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 8; i++) drive_rx(8'hA0 + 8'(i));
        check_eq("rx_full_ready", {31'b0, rx_ready}, 32'h0);
        rx_data = 8'hA8; rx_valid = 1'b1;
        do_read(A_RX, 32'hA0, "rx_pop_full");
        check_eq("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("rx_refull_ready", {31'b0, rx_ready}, 32'h0);
        for (int i = 1; i <= 8; i++) do_read(A_RX, 32'hA0 + i, "rx_drain_wrap");
        do_read(A_RX, 32'h0, "rx_drained_empty");
`else
        drive_rx(8'h55);
        check_eq("rx_full_ready", {31'b0, rx_ready}, 32'h0);
        rx_data = 8'h66; rx_valid = 1'b1;
        do_read(A_RX, 32'h55, "rx_pop_full");
        check_eq("rx_ready_after_pop", {31'b0, rx_ready}, 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("rx_refull_ready", {31'b0, rx_ready}, 32'h0);
        do_read(A_RX, 32'h66, "rx_pop_66");
        do_read(A_RX, 32'h0, "rx_drained_empty");
`endif

        // Counters: clear beats a same-cycle retire
        inst_retired = 1'b1;
        do_write(A_CLR, 32'hDEAD_BEEF);
        inst_retired = 1'b0;
        do_read(A_INS, 32'h0, "ins_clear_priority");
        for (int i = 0; i < 10; i++) begin
            inst_retired = (i == 1 || i == 4 || i == 8);
            @(negedge clk);
        end
        inst_retired = 1'b0;
        do_read(A_INS, 32'h3, "ins_count3");
        do_read(32'h4000_0014, 32'h0, "ins_miss_reads0");

        for (int k = 0; k < 3; k++) begin
            m = $urandom_range(0, 20);
            do_write(A_CLR, 32'h0);
            repeat (m) @(negedge clk);
            do_read(A_CYC, 32'(m), "cyc_since_clear");
        end

        force dut.cyc_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cyc_cnt_q;
        do_read(A_CYC, 32'hFFFF_FFFF, "cyc_at_max");
        do_read(A_CYC, 32'h0, "cyc_wrap");

        // Reset in the middle of pending TX and RX traffic
        do_write(A_TX, 32'h5A);
        drive_rx(8'h77);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check_eq("midrst_rx_ready", {31'b0, rx_ready}, 32'h1);
        check_eq("midrst_rdata", rdata, 32'h0);
        do_read(A_STAT, 32'h1, "midrst_stat");
        do_read(A_RX, 32'h0, "midrst_rx_empty");

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
